// File: rtl/blram_pkg.sv
// ---------------------------------------------------------------------------
// blram_pkg
// Shared constants and helpers for the dual-port block RAM (blram_dp).
//   RDW_READ_FIRST / RDW_WRITE_FIRST : same-port read-during-write modes
//   BYTES                            : byte lanes of the default 32-bit word
//   byte_par()                       : per-byte even-parity vector
//   byte_merge()                     : byte-enable merge of old and new words
// The helpers work on MAX_DATA_W-wide vectors so that any DATA_W up to that
// size can use them; callers zero-extend the inputs and truncate the result.
// ---------------------------------------------------------------------------
package blram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int DEF_DATA_W = 32;
    localparam int BYTES      = DEF_DATA_W / 8;

    localparam int MAX_DATA_W = 512;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    typedef logic [MAX_DATA_W-1:0] word_t;
    typedef logic [MAX_BYTES-1:0]  lane_t;

    // Even parity: the stored bit makes the count of ones in byte+bit even.
    function automatic lane_t byte_par(input word_t w);
        lane_t p;
        p = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

    function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                         input lane_t we);
        word_t m;
        m = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (we[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/blram_rd_pipe.sv
// ---------------------------------------------------------------------------
// blram_rd_pipe
// Read output pipeline for one RAM port: the array read register followed by
// RD_LATENCY-1 extra plain register stages.
//   clk, rst      : clock, synchronous active-high flush
//   fire          : a read was accepted this cycle (capture cap_data)
//   cap_data      : payload to capture (read word, plus parity flag if built)
//   out_valid     : one-cycle read-valid strobe
//   out_data      : payload; holds its last value while no read completes
// ---------------------------------------------------------------------------
module blram_rd_pipe #(
    parameter int RD_LATENCY = 1,
    parameter int PAY_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic [PAY_W-1:0] cap_data,
    output logic             out_valid,
    output logic [PAY_W-1:0] out_data
);

    // Index 0 is the array read register; later indices are the extra stages.
    logic             valid_reg [RD_LATENCY];
    logic [PAY_W-1:0] data_reg  [RD_LATENCY];

    // Read register only loads on an accepted read so data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg[0] <= 1'b0;
            data_reg[0]  <= '0;
        end else begin
            valid_reg[0] <= fire;
            if (fire) begin
                data_reg[0] <= cap_data;
            end
        end
    end

    // Extra stages copy every cycle; holding is inherited from stage 0.
    genvar gi;
    for (gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
            end else begin
                valid_reg[gi] <= valid_reg[gi-1];
                data_reg[gi]  <= data_reg[gi-1];
            end
        end
    end

    assign out_valid = valid_reg[RD_LATENCY-1];
    assign out_data  = data_reg[RD_LATENCY-1];

endmodule

// File: rtl/blram_dp.sv
// ---------------------------------------------------------------------------
// blram_dp
// True-dual-port block RAM with byte write enables, 1- or 2-cycle read
// latency, selectable same-port read-during-write and cross-port collision
// flag. Port A: CPU traffic, port B: second master (DMA/debug/loader).
//   clk, rst                     : clock, synchronous active-high reset
//   i_x_en / i_x_we / i_x_addr   : request, byte enables (0 = read), address
//   i_x_wdata                    : write data
//   o_x_rdata / o_x_rvalid       : read data and one-cycle valid strobe
//   o_collision                  : both ports wrote the same word last cycle
//   o_par_err                    : parity error with rvalid (either port)
// Optional feature: define BLRAM_PARITY_EN to store one even-parity bit per
// byte and check it on reads; otherwise o_par_err is tied to 0.
// Reset clears outputs and the read pipeline only; the array keeps its data
// and writes presented during reset still land.
// ---------------------------------------------------------------------------
module blram_dp
    import blram_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 1024,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_a_en,
    input  logic [DATA_W/8-1:0] i_a_we,
    input  logic [ADDR_W-1:0]   i_a_addr,
    input  logic [DATA_W-1:0]   i_a_wdata,
    output logic [DATA_W-1:0]   o_a_rdata,
    output logic                o_a_rvalid,
    input  logic                i_b_en,
    input  logic [DATA_W/8-1:0] i_b_we,
    input  logic [ADDR_W-1:0]   i_b_addr,
    input  logic [DATA_W-1:0]   i_b_wdata,
    output logic [DATA_W-1:0]   o_b_rdata,
    output logic                o_b_rvalid,
    output logic                o_collision,
    output logic                o_par_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
`ifdef BLRAM_PARITY_EN
    localparam int PAY_W = DATA_W + 1;
`else
    localparam int PAY_W = DATA_W;
`endif

    logic [DATA_W-1:0] mem_data [DEPTH];
`ifdef BLRAM_PARITY_EN
    logic [NB-1:0]     mem_par  [DEPTH];
`endif

    // Ports gathered into 2-entry arrays: index 0 = A, 1 = B.
    logic              en       [2];
    logic [NB-1:0]     we       [2];
    logic [ADDR_W-1:0] addr     [2];
    logic [DATA_W-1:0] wdata    [2];
    logic              in_range [2];
    logic [IDX_W-1:0]  idx      [2];
    logic [DATA_W-1:0] out_rdata [2];
    logic              out_valid [2];
`ifdef BLRAM_PARITY_EN
    logic              out_err   [2];
`endif

    assign en[0] = i_a_en;    assign we[0] = i_a_we;
    assign addr[0] = i_a_addr; assign wdata[0] = i_a_wdata;
    assign en[1] = i_b_en;    assign we[1] = i_b_we;
    assign addr[1] = i_b_addr; assign wdata[1] = i_b_wdata;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_addr
        // Full-width compare: addresses past DEPTH never alias onto the array.
        assign in_range[gi] = ({1'b0, addr[gi]} < DEPTH_A);
        assign idx[gi]      = addr[gi][IDX_W-1:0];
    end

    // Port B is applied first and port A last, so on a same-word double
    // write A's enabled bytes override B's while B's other bytes still land.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (en[p] && in_range[p]) begin
                for (int i = 0; i < NB; i++) begin
                    if (we[p][i]) begin
                        mem_data[idx[p]][8*i +: 8] <= wdata[p][8*i +: 8];
`ifdef BLRAM_PARITY_EN
                        mem_par[idx[p]][i] <= ^wdata[p][8*i +: 8];
`endif
                    end
                end
            end
        end
    end

    for (gi = 0; gi < 2; gi++) begin : g_port
        logic              full_we;
        logic              partial;
        logic              rd_fire;
        logic [DATA_W-1:0] old_word;
        logic [DATA_W-1:0] rd_word;
        logic [PAY_W-1:0]  cap_data;
        logic [PAY_W-1:0]  out_pay;

        assign full_we  = &we[gi];
        assign partial  = (|we[gi]) && !full_we;
        // Reads and partial writes return data; full writes never do.
        assign rd_fire  = en[gi] && !full_we;
        // Pre-edge array contents, so the other port's same-cycle write is unseen.
        assign old_word = mem_data[idx[gi]];

        always_comb begin
            rd_word = old_word;
            if (!in_range[gi]) begin
                rd_word = '0;
            end else if (RDW_MODE == RDW_WRITE_FIRST && partial) begin
                rd_word = DATA_W'(byte_merge(MAX_DATA_W'(old_word),
                                             MAX_DATA_W'(wdata[gi]),
                                             MAX_BYTES'(we[gi])));
            end
        end

`ifdef BLRAM_PARITY_EN
        logic par_bad;
        // Out-of-range reads never flag.
        assign par_bad  = in_range[gi] &&
                          (byte_par(MAX_DATA_W'(old_word)) != MAX_BYTES'(mem_par[idx[gi]]));
        assign cap_data = {par_bad, rd_word};
        assign out_rdata[gi] = out_pay[DATA_W-1:0];
        assign out_err[gi]   = out_pay[DATA_W];
`else
        assign cap_data = rd_word;
        assign out_rdata[gi] = out_pay;
`endif

        blram_rd_pipe #(
            .RD_LATENCY (RD_LATENCY),
            .PAY_W      (PAY_W)
        ) u_rd_pipe (
            .clk       (clk),
            .rst       (rst),
            .fire      (rd_fire),
            .cap_data  (cap_data),
            .out_valid (out_valid[gi]),
            .out_data  (out_pay)
        );
    end

    assign o_a_rdata  = out_rdata[0];
    assign o_a_rvalid = out_valid[0];
    assign o_b_rdata  = out_rdata[1];
    assign o_b_rvalid = out_valid[1];

`ifdef BLRAM_PARITY_EN
    // The error bit travels with held data, so gate it by the valid strobe.
    assign o_par_err = (out_valid[0] && out_err[0]) || (out_valid[1] && out_err[1]);
`else
    assign o_par_err = 1'b0;
`endif

    logic collision_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= en[0] && en[1] && (|we[0]) && (|we[1]) &&
                             in_range[0] && in_range[1] && (addr[0] == addr[1]);
        end
    end
    assign o_collision = collision_reg;

endmodule
